alu_input_sequencer: RTL and testbench

ALU_INPUT_SEQUENCER -- requirements
Module: alu_input_sequencer

---
 rtl/alu_input_sequencer_pkg.sv | 43 ++++
 rtl/alu_input_sequencer_key_debounce.sv | 52 +++++
 rtl/alu_input_sequencer.sv | 114 +++++++++++
 tb/tb_alu_input_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_input_sequencer_pkg.sv
// Shared types and constants for the pushbutton-driven ALU operand sequencer.
package alu_input_sequencer_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    ISSUE   = 2'd3
  } seq_state_t;

  localparam int unsigned KEY_ENTER  = 0;
  localparam int unsigned KEY_CLEAR  = 1;
  localparam int unsigned KEY_SIGNED = 2;
  localparam int unsigned KEY_REPEAT = 3;
  localparam int unsigned NUM_KEYS   = 4;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SW_W     = 16;

  typedef logic [OPCODE_W-1:0] aluop_t;

  // Only the highest-priority key event in a cycle is acted upon.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CLEAR,
    ACT_SIGNED,
    ACT_ENTER,
    ACT_REPEAT
  } key_act_t;

  function automatic logic [DATA_W-1:0] extend_sw(input logic [SW_W-1:0] sw_val,
                                                  input logic            signed_ext);
    logic [DATA_W-1:0] ext;
    if (signed_ext) begin
      ext = {{(DATA_W-SW_W){sw_val[SW_W-1]}}, sw_val};
    end else begin
      ext = {{(DATA_W-SW_W){1'b0}}, sw_val};
    end
    return ext;
  endfunction

endpackage

// File: rtl/alu_input_sequencer_key_debounce.sv
// One pushbutton: 2-flop synchronizer, stable-count debouncer, press-edge pulse.
module key_debounce #(
  parameter int unsigned DB_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

  // Everything is held in "pressed" polarity so reset value 0 means released.
  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_prev_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= ~key_ni;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/alu_input_sequencer.sv
// Collects operand A, operand B and opcode from switches via debounced keys,
// then issues them to the ALU with a one-cycle valid pulse.
module alu_input_sequencer
  import alu_input_sequencer_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 250000
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [SW_W-1:0]     sw,
  output logic [DATA_W-1:0]   porta,
  output logic [DATA_W-1:0]   portb,
  output logic [OPCODE_W-1:0] aluop,
  output logic                valid,
  output logic [1:0]          state
);

  logic [NUM_KEYS-1:0] press;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_key_debounce (
      .clk_i  (CLK),
      .rst_ni (nRST),
      .key_ni (key_n[g]),
      .press_o(press[g])
    );
  end

  key_act_t act;

  always_comb begin
    act = ACT_NONE;
    if (press[KEY_CLEAR]) begin
      act = ACT_CLEAR;
    end else if (press[KEY_SIGNED]) begin
      act = ACT_SIGNED;
    end else if (press[KEY_ENTER]) begin
      act = ACT_ENTER;
    end else if (press[KEY_REPEAT]) begin
      act = ACT_REPEAT;
    end
  end

  seq_state_t        state_q;
  logic [DATA_W-1:0] porta_q, portb_q;
  aluop_t            aluop_q;
  logic              valid_q;
  logic              issued_q;
  logic              capture;
  logic [DATA_W-1:0] operand;

  assign capture = (act == ACT_SIGNED) || (act == ACT_ENTER);
  assign operand = extend_sw(sw, act == ACT_SIGNED);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= LOAD_A;
      porta_q  <= '0;
      portb_q  <= '0;
      aluop_q  <= '0;
      valid_q  <= 1'b0;
      issued_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        LOAD_A: begin
          if (act == ACT_CLEAR) begin
            issued_q <= 1'b0;
          end else if (capture) begin
            porta_q <= operand;
            state_q <= LOAD_B;
          end else if (act == ACT_REPEAT && issued_q) begin
            state_q <= ISSUE;
            valid_q <= 1'b1;
          end
        end
        LOAD_B: begin
          if (act == ACT_CLEAR) begin
            issued_q <= 1'b0;
            state_q  <= LOAD_A;
          end else if (capture) begin
            portb_q <= operand;
            state_q <= LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (act == ACT_CLEAR) begin
            issued_q <= 1'b0;
            state_q  <= LOAD_A;
          end else if (capture) begin
            aluop_q <= sw[OPCODE_W-1:0];
            state_q <= ISSUE;
            valid_q <= 1'b1;
          end
        end
        ISSUE: begin
          issued_q <= 1'b1;
          state_q  <= LOAD_A;
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

  assign porta = porta_q;
  assign portb = portb_q;
  assign aluop = aluop_q;
  assign valid = valid_q;
  assign state = state_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Self-checking bench for alu_input_sequencer with a short debounce window.
module tb_alu_input_sequencer;

  localparam int DB = 4;
  // Output update lands one edge after the press pulse (pulse at DB+3).
  localparam int UPDATE_EDGE = DB + 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [3:0]  key_n;
  logic [15:0] sw;
  logic [31:0] porta, portb;
  logic [3:0]  aluop;
  logic        valid;
  logic [1:0]  state;

  alu_input_sequencer #(
    .DB_CYCLES(DB)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .key_n(key_n),
    .sw   (sw),
    .porta(porta),
    .portb(portb),
    .aluop(aluop),
    .valid(valid),
    .state(state)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  int   vcount = 0;
  int   consec = 0;
  logic prev_v = 1'b0;

  always @(negedge CLK) begin
    if (valid === 1'b1) begin
      vcount = vcount + 1;
      if (prev_v) consec = consec + 1;
    end
    prev_v = (valid === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Transaction-level reference: one resolved key action per press.
  int          m_state;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;
  bit          m_issued;

  task automatic model_reset();
    m_state = 0; m_a = '0; m_b = '0; m_op = '0; m_issued = 0;
  endtask

  task automatic model_apply(input logic [3:0] mask, input logic [15:0] s, output int nv);
    logic [31:0] v;
    nv = 0;
    v  = mask[2] ? {{16{s[15]}}, s} : {16'h0000, s};
    if (mask[1]) begin
      m_state = 0; m_issued = 0;
    end else if (mask[2] || mask[0]) begin
      if (m_state == 0) begin
        m_a = v; m_state = 1;
      end else if (m_state == 1) begin
        m_b = v; m_state = 2;
      end else begin
        m_op = s[3:0]; m_state = 0; m_issued = 1; nv = 1;
      end
    end else if (mask[3] && m_state == 0 && m_issued) begin
      nv = 1;
    end
  endtask

  task automatic press(input logic [3:0] mask, input logic [15:0] s);
    @(negedge CLK);
    sw    = s;
    key_n = ~mask;
    repeat (10) @(negedge CLK);
    key_n = 4'hF;
    repeat (12) @(negedge CLK);
  endtask

  task automatic check_all(input string tag, input logic [1:0] es, input logic [31:0] ea,
                           input logic [31:0] eb, input logic [3:0] eop, input int env, input int nv);
    check({tag, "_state"}, {30'd0, state}, {30'd0, es});
    check({tag, "_porta"}, porta, ea);
    check({tag, "_portb"}, portb, eb);
    check({tag, "_aluop"}, {28'd0, aluop}, {28'd0, eop});
    check({tag, "_valids"}, nv, env);
  endtask

  // Edges counted from the one that first samples the new key level (edge 0).
  task automatic wait_change(input logic [1:0] st0, output int edges);
    edges = -1;
    for (int k = 0; k <= 40; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (state !== st0) begin
        edges = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] sw;
    logic [1:0]  st;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    int          nv;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int v0, nv, lat;
    logic [3:0]  mask;
    logic [15:0] s;

    tbl[0]  = '{4'h8, 16'h0000, 2'd0, 32'h00000000, 32'h00000000, 4'h0, 0};
    tbl[1]  = '{4'h1, 16'h0005, 2'd1, 32'h00000005, 32'h00000000, 4'h0, 0};
    tbl[2]  = '{4'h1, 16'h0003, 2'd2, 32'h00000005, 32'h00000003, 4'h0, 0};
    tbl[3]  = '{4'h1, 16'h0002, 2'd0, 32'h00000005, 32'h00000003, 4'h2, 1};
    tbl[4]  = '{4'h8, 16'h0009, 2'd0, 32'h00000005, 32'h00000003, 4'h2, 1};
    tbl[5]  = '{4'h4, 16'h8001, 2'd1, 32'hFFFF8001, 32'h00000003, 4'h2, 0};
    tbl[6]  = '{4'h1, 16'h8001, 2'd2, 32'hFFFF8001, 32'h00008001, 4'h2, 0};
    tbl[7]  = '{4'h2, 16'h0000, 2'd0, 32'hFFFF8001, 32'h00008001, 4'h2, 0};
    tbl[8]  = '{4'h8, 16'h0000, 2'd0, 32'hFFFF8001, 32'h00008001, 4'h2, 0};
    tbl[9]  = '{4'h1, 16'h1234, 2'd1, 32'h00001234, 32'h00008001, 4'h2, 0};
    tbl[10] = '{4'h3, 16'h7777, 2'd0, 32'h00001234, 32'h00008001, 4'h2, 0};
    tbl[11] = '{4'h5, 16'h8ABC, 2'd1, 32'hFFFF8ABC, 32'h00008001, 4'h2, 0};
    tbl[12] = '{4'h9, 16'h0042, 2'd2, 32'hFFFF8ABC, 32'h00000042, 4'h2, 0};
    tbl[13] = '{4'h4, 16'hF00D, 2'd0, 32'hFFFF8ABC, 32'h00000042, 4'hD, 1};
    tbl[14] = '{4'hA, 16'h0000, 2'd0, 32'hFFFF8ABC, 32'h00000042, 4'hD, 0};
    tbl[15] = '{4'h8, 16'h0000, 2'd0, 32'hFFFF8ABC, 32'h00000042, 4'hD, 0};

    nRST  = 1'b0;
    key_n = 4'hF;
    sw    = 16'h0000;
    model_reset();
    repeat (3) @(negedge CLK);
    check_all("reset", 2'd0, 32'h0, 32'h0, 4'h0, 0, vcount);
    nRST = 1'b1;
    repeat (3) @(negedge CLK);

    for (int i = 0; i < 16; i++) begin
      v0 = vcount;
      press(tbl[i].mask, tbl[i].sw);
      model_apply(tbl[i].mask, tbl[i].sw, nv);
      check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].a, tbl[i].b, tbl[i].op,
                tbl[i].nv, vcount - v0);
    end

    for (int i = 0; i < 30; i++) begin
      mask = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 2) != 0) mask[1] = 1'b0;
      if (mask == 4'h0) mask = 4'h1;
      s  = 16'($urandom);
      v0 = vcount;
      press(mask, s);
      model_apply(mask, s, nv);
      check_all($sformatf("rnd%0d", i), 2'(m_state), m_a, m_b, m_op, nv, vcount - v0);
    end

    // Bouncing ENTER, then a clean hold: exactly one event at fixed latency.
    sw = 16'h00A5;
    for (int i = 0; i < 5; i++) begin
      key_n[0] = 1'b0;
      repeat (2) @(negedge CLK);
      key_n[0] = 1'b1;
      repeat (2) @(negedge CLK);
    end
    check("bounce_nochange", {30'd0, state}, 32'(m_state));
    v0 = vcount;
    key_n[0] = 1'b0;
    wait_change(state, lat);
    check("bounce_latency", lat, UPDATE_EDGE);
    repeat (20) @(negedge CLK);
    key_n[0] = 1'b1;
    repeat (12) @(negedge CLK);
    model_apply(4'h1, 16'h00A5, nv);
    check_all("bounce", 2'(m_state), m_a, m_b, m_op, nv, vcount - v0);

    // Reset while in LOAD_OP.
    press(4'h2, 16'h0000);
    model_apply(4'h2, 16'h0000, nv);
    press(4'h1, 16'h0011);
    model_apply(4'h1, 16'h0011, nv);
    press(4'h1, 16'h0022);
    model_apply(4'h1, 16'h0022, nv);
    check("loadop_state", {30'd0, state}, 32'd2);
    nRST = 1'b0;
    #1;
    check_all("rst_op_async", 2'd0, 32'h0, 32'h0, 4'h0, 0, {31'd0, valid});
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    v0 = vcount;
    repeat (20) @(negedge CLK);
    check_all("rst_op_after", 2'd0, 32'h0, 32'h0, 4'h0, 0, vcount - v0);
    model_reset();

    // Reset landing in the ISSUE cycle.
    press(4'h1, 16'h0033);
    press(4'h1, 16'h0044);
    sw = 16'h0007;
    key_n[0] = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (state === 2'd3) begin
        lat = k;
        break;
      end
    end
    check("reach_issue", {31'd0, lat >= 0}, 32'd1);
    nRST = 1'b0;
    #1;
    check("rst_issue_valid", {31'd0, valid}, 32'd0);
    check("rst_issue_state", {30'd0, state}, 32'd0);
    key_n = 4'hF;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    v0 = vcount;
    repeat (20) @(negedge CLK);
    check_all("rst_issue_after", 2'd0, 32'h0, 32'h0, 4'h0, 0, vcount - v0);

    // Key held across reset release: one event, same latency as a fresh press.
    nRST = 1'b0;
    sw = 16'h0BEE;
    key_n[0] = 1'b0;
    repeat (5) @(negedge CLK);
    nRST = 1'b1;
    wait_change(2'd0, lat);
    check("held_rst_latency", lat, UPDATE_EDGE);
    repeat (30) @(negedge CLK);
    check_all("held_rst", 2'd1, 32'h00000BEE, 32'h0, 4'h0, 0, 0);
    key_n = 4'hF;
    repeat (12) @(negedge CLK);

    check("valid_never_consecutive", consec, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
